aes_vector_sequencer: RTL

//  Source side of the aes_128 state/key inputs. Holds a small table of plaintext

---
 rtl/aes_vector_sequencer_if.sv | 41 ++++
 rtl/aes_vector_sequencer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/aes_vector_sequencer_if.sv
// Bus bundle between aes_vector_sequencer and its host/AES neighbour.
// The stop signal exists only when SEQ_LOOP_EN is defined.
interface aes_vector_sequencer_if #(
  parameter int AW = 3,
  parameter int GW = 4
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [127:0]  wr_pt;
  logic          key_load;
  logic [127:0]  key_in;
  logic          start;
  logic [AW:0]   count;
  logic [GW-1:0] gap;
`ifdef SEQ_LOOP_EN
  logic          stop;
`endif
  logic [127:0]  state;
  logic [127:0]  key;
  logic          in_valid;
  logic          ct_valid;
  logic [AW-1:0] ct_index;
  logic          busy;
  logic          done;

  modport master (
`ifdef SEQ_LOOP_EN
    output stop,
`endif
    output wr_en, wr_addr, wr_pt, key_load, key_in, start, count, gap,
    input  state, key, in_valid, ct_valid, ct_index, busy, done
  );

  modport slave (
`ifdef SEQ_LOOP_EN
    input  stop,
`endif
    input  wr_en, wr_addr, wr_pt, key_load, key_in, start, count, gap,
    output state, key, in_valid, ct_valid, ct_index, busy, done
  );
endinterface

// File: rtl/aes_vector_sequencer.sv
// Streams a plaintext table into aes_128 and tags ciphertexts with their table index.
// Define SEQ_LOOP_EN to loop the table until bus.stop is seen.
module aes_vector_sequencer #(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int LATENCY = 21,
  parameter int GW      = 4
) (
  input logic                  clk,
  input logic                  rst,
  aes_vector_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, GAP, DRAIN} state_t;

  state_t        fsm, fsm_d;
  logic [127:0]  tbl [DEPTH];
  logic [127:0]  state_q, key_q;
  logic          in_valid_q, done_q;
  logic [AW-1:0] idx, cur_idx, last_idx, issue_idx, last_c, last_eff;
  logic [AW:0]   cnt_c;
  logic [GW-1:0] gap_l, gap_cnt, gap_cnt_d;
  logic          issue, start_ok, last, halt;
  logic [LATENCY-1:0] pv, pv_d;
  logic [AW-1:0] pi [LATENCY];
`ifdef SEQ_LOOP_EN
  logic          stop_seen;
`endif

  assign start_ok = (fsm == IDLE) && bus.start && (bus.count != '0) && !done_q;
  assign cnt_c    = (bus.count > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.count;
  assign last_c   = AW'(cnt_c - 1'b1);
  assign last_eff = start_ok ? last_c : last_idx;
  assign pv_d     = (pv << 1) | LATENCY'(in_valid_q);

`ifdef SEQ_LOOP_EN
  assign halt = stop_seen | bus.stop;
  assign last = halt;
`else
  assign halt = 1'b0;
  assign last = (cur_idx == last_idx);
`endif

  always_comb begin
    fsm_d     = fsm;
    issue     = 1'b0;
    issue_idx = idx;
    gap_cnt_d = gap_cnt;
    unique case (fsm)
      IDLE: if (start_ok) begin
        fsm_d     = ISSUE;
        issue     = 1'b1;
        issue_idx = '0;
      end
      ISSUE: begin
        if (last)               fsm_d = DRAIN;
        else if (gap_l == '0)   issue = 1'b1;
        else begin
          fsm_d     = GAP;
          gap_cnt_d = gap_l;
        end
      end
      GAP: begin
        if (halt) fsm_d = DRAIN;
        else if (gap_cnt == GW'(1)) begin
          fsm_d = ISSUE;
          issue = 1'b1;
        end else gap_cnt_d = gap_cnt - 1'b1;
      end
      // Pipe empty after this edge means the last tag has just left ct_valid.
      DRAIN: if (pv_d == '0) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm        <= IDLE;
      idx        <= '0;
      cur_idx    <= '0;
      last_idx   <= '0;
      gap_l      <= '0;
      gap_cnt    <= '0;
      state_q    <= '0;
      key_q      <= '0;
      in_valid_q <= 1'b0;
      done_q     <= 1'b0;
      pv         <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) pi[i] <= '0;
`ifdef SEQ_LOOP_EN
      stop_seen  <= 1'b0;
`endif
    end else begin
      fsm        <= fsm_d;
      gap_cnt    <= gap_cnt_d;
      in_valid_q <= issue;
      done_q     <= (fsm == DRAIN) && (fsm_d == IDLE);
      pv         <= pv_d;
      pi[0]      <= cur_idx;
      for (int unsigned i = 1; i < LATENCY; i++) pi[i] <= pi[i-1];
      if (start_ok) begin
        last_idx <= last_c;
        gap_l    <= bus.gap;
      end
      if (issue) begin
        state_q <= tbl[issue_idx];
        cur_idx <= issue_idx;
        idx     <= (issue_idx == last_eff) ? '0 : issue_idx + 1'b1;
      end
      if (fsm == IDLE && bus.key_load) key_q <= bus.key_in;
`ifdef SEQ_LOOP_EN
      if (start_ok)                      stop_seen <= 1'b0;
      else if (fsm != IDLE && bus.stop)  stop_seen <= 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (bus.wr_en && fsm == IDLE) tbl[bus.wr_addr] <= bus.wr_pt;
  end

  assign bus.state    = state_q;
  assign bus.key      = key_q;
  assign bus.in_valid = in_valid_q;
  assign bus.ct_valid = pv[LATENCY-1];
  assign bus.ct_index = pi[LATENCY-1];
  assign bus.busy     = (fsm != IDLE);
  assign bus.done     = done_q;
endmodule
